// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the EX-stage branch resolver: funct3 encodings,
// redirect FSM states and the BHT counter reset value.
package branch_resolve_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Weak not-taken: first encounter of a branch predicts fall-through.
    localparam logic [1:0] BHT_RESET = 2'b01;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

endpackage

// File: rtl/br_bht.sv
// Branch history table of 2-bit saturating counters, indexed by word-aligned
// PC bits, with one combinational read port and one update port.
module br_bht
    import branch_resolve_pkg::*;
#(
    parameter int PCW     = 32,
    parameter int BHT_IDX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [PCW-1:0] rd_pc,
    output logic           rd_taken,
    input  logic           upd_en,
    input  logic [PCW-1:0] upd_pc,
    input  logic           upd_taken
);

    localparam int ENTRIES = 1 << BHT_IDX;

    logic [1:0]         ctr [ENTRIES];
    logic [BHT_IDX-1:0] rd_idx;
    logic [BHT_IDX-1:0] upd_idx;

    assign rd_idx   = rd_pc[BHT_IDX+1:2];
    assign upd_idx  = upd_pc[BHT_IDX+1:2];
    // Read sees the pre-update value when read and write hit the same entry.
    assign rd_taken = ctr[rd_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= BHT_RESET;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                if (ctr[upd_idx] != 2'b11) ctr[upd_idx] <= ctr[upd_idx] + 2'b01;
            end else begin
                if (ctr[upd_idx] != 2'b00) ctr[upd_idx] <= ctr[upd_idx] - 2'b01;
            end
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{rd_pc[PCW-1:BHT_IDX+2], rd_pc[1:0],
                              upd_pc[PCW-1:BHT_IDX+2], upd_pc[1:0]};

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: decides taken/not-taken from comparator flags,
// detects mispredicts, and holds a PC redirect to fetch until it is accepted.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int PCW     = 32,
    parameter int BHT_IDX = 4,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_is_jump,
    input  logic [2:0]      ex_funct3,
    input  logic [PCW-1:0]  ex_pc,
    input  logic [PCW-1:0]  ex_target,
    input  logic            ex_pred_taken,
    output logic            br_un,
    input  logic            br_eq,
    input  logic            br_lt,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [PCW-1:0]  redir_pc,
    output logic            stall,
    input  logic [PCW-1:0]  pred_pc,
    output logic            pred_taken,
    output logic [CNTW-1:0] mispred_cnt
);

    state_t         state_q;
    state_t         state_d;
    logic           taken;
    logic           cond_branch;
    logic           accepted;
    logic           mispredict;
    logic [PCW-1:0] correct_pc;

    assign br_un = ex_funct3[1];

    // Illegal funct3 resolves not-taken and is excluded from BHT training.
    always_comb begin
        taken       = 1'b0;
        cond_branch = 1'b0;
        if (ex_is_jump) begin
            taken = 1'b1;
        end else begin
            case (ex_funct3)
                F3_BEQ:           begin taken = br_eq;  cond_branch = 1'b1; end
                F3_BNE:           begin taken = !br_eq; cond_branch = 1'b1; end
                F3_BLT, F3_BLTU:  begin taken = br_lt;  cond_branch = 1'b1; end
                F3_BGE, F3_BGEU:  begin taken = !br_lt; cond_branch = 1'b1; end
                default:          ;
            endcase
        end
    end

    // Instructions arriving while a redirect is pending are wrong-path.
    assign accepted   = ex_valid && (state_q == ST_IDLE);
    assign mispredict = accepted && (taken != ex_pred_taken);
    assign correct_pc = taken ? ex_target : ex_pc + PCW'(4);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (mispredict)  state_d = ST_REDIRECT;
            ST_REDIRECT: if (redir_ready) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            mispred_cnt <= '0;
        end else begin
            state_q     <= state_d;
            redir_valid <= (state_d == ST_REDIRECT);
            if (mispredict) begin
                redir_pc <= correct_pc;
                if (mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNTW'(1);
            end
        end
    end

    assign stall = (state_q == ST_REDIRECT);

    br_bht #(
        .PCW     (PCW),
        .BHT_IDX (BHT_IDX)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_pc     (pred_pc),
        .rd_taken  (pred_taken),
        .upd_en    (accepted && cond_branch),
        .upd_pc    (ex_pc),
        .upd_taken (taken)
    );

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed vectors, a rule-level model
// compared every cycle, and literal checks that pin the model.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_is_jump, ex_pred_taken;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_target, pred_pc, redir_pc;
    logic        br_un, br_eq, br_lt;
    logic        redir_valid, redir_ready, stall, pred_taken;
    logic [15:0] mispred_cnt;

    int tests    = 0;
    int failures = 0;
    bit checking = 0;

    branch_resolve #(.PCW(32), .BHT_IDX(4), .CNTW(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_is_jump    (ex_is_jump),
        .ex_funct3     (ex_funct3),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .br_un         (br_un),
        .br_eq         (br_eq),
        .br_lt         (br_lt),
        .redir_valid   (redir_valid),
        .redir_ready   (redir_ready),
        .redir_pc      (redir_pc),
        .stall         (stall),
        .pred_pc       (pred_pc),
        .pred_taken    (pred_taken),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    // Rule-level model: bit2 picks less-than vs equal, bit0 inverts the sense.
    function automatic logic model_taken(input logic jump, input logic [2:0] f3,
                                         input logic eq, input logic lt);
        if (jump) return 1'b1;
        if (f3 == 3'd2 || f3 == 3'd3) return 1'b0;
        return (f3[2] ? lt : eq) ^ f3[0];
    endfunction

    function automatic logic model_is_cond(input logic jump, input logic [2:0] f3);
        return !jump && f3 != 3'd2 && f3 != 3'd3;
    endfunction

    function automatic int sat_step(input int v, input logic up);
        if (up) return (v >= 3) ? 3 : v + 1;
        return (v <= 0) ? 0 : v - 1;
    endfunction

    int          model_ctr [16] = '{default: 1};
    bit          model_pending  = 0;
    logic [31:0] model_rpc      = 32'h0;
    int          model_cnt      = 0;
    logic        m_taken, m_cond;

    assign m_taken = model_taken(ex_is_jump, ex_funct3, br_eq, br_lt);
    assign m_cond  = model_is_cond(ex_is_jump, ex_funct3);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) model_ctr[i] <= 1;
            model_pending <= 0;
            model_rpc     <= 32'h0;
            model_cnt     <= 0;
        end else if (model_pending) begin
            if (redir_ready) model_pending <= 0;
        end else if (ex_valid) begin
            if (m_cond) model_ctr[ex_pc[5:2]] <= sat_step(model_ctr[ex_pc[5:2]], m_taken);
            if (m_taken != ex_pred_taken) begin
                model_pending <= 1;
                model_rpc     <= m_taken ? ex_target : ex_pc + 32'd4;
                if (model_cnt < 65535) model_cnt <= model_cnt + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("model_redir_valid", {31'b0, redir_valid}, {31'b0, model_pending});
            checkOutput("model_stall", {31'b0, stall}, {31'b0, model_pending});
            checkOutput("model_redir_pc", redir_pc, model_rpc);
            checkOutput("model_mispred_cnt", {16'b0, mispred_cnt}, model_cnt);
            checkOutput("model_br_un", {31'b0, br_un}, {31'b0, ex_funct3[1]});
            checkOutput("model_pred_taken", {31'b0, pred_taken},
                        {31'b0, model_ctr[pred_pc[5:2]] >= 2});
        end
    end

    task automatic applyStimulus(input logic v, input logic j, input logic [2:0] f3,
                                 input logic [31:0] pc, input logic [31:0] tgt,
                                 input logic pred, input logic eq, input logic lt,
                                 input logic rdy);
        ex_valid      = v;
        ex_is_jump    = j;
        ex_funct3     = f3;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
        br_eq         = eq;
        br_lt         = lt;
        redir_ready   = rdy;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic releaseRedirect();
        applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 1);
        step();
        checkOutput("release_redir_valid", {31'b0, redir_valid}, 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        pred_pc = 32'h0;
        applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checking = 1;
        #1;
        checkOutput("reset_redir_valid", {31'b0, redir_valid}, 32'd0);
        checkOutput("reset_redir_pc", redir_pc, 32'h0);
        checkOutput("reset_cnt", {16'b0, mispred_cnt}, 32'd0);
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);
        checkOutput("reset_pred", {31'b0, pred_taken}, 32'd0);

        // BEQ taken but predicted not-taken.
        applyStimulus(1, 0, 3'b000, 32'h40, 32'h100, 0, 1, 0, 0);
        step();
        checkOutput("beq_redir_valid", {31'b0, redir_valid}, 32'd1);
        checkOutput("beq_redir_pc", redir_pc, 32'h100);
        checkOutput("beq_stall", {31'b0, stall}, 32'd1);
        checkOutput("beq_cnt", {16'b0, mispred_cnt}, 32'd1);
        pred_pc = 32'h40;
        #1 checkOutput("beq_bht_trained", {31'b0, pred_taken}, 32'd1);

        // Fetch back-pressure with wrong-path mispredicting branches in EX.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(i != 1, 0, 3'b000, 32'h80, 32'h300, 1, 0, 0, 0);
            step();
            checkOutput("hold_redir_valid", {31'b0, redir_valid}, 32'd1);
            checkOutput("hold_redir_pc", redir_pc, 32'h100);
            checkOutput("hold_stall", {31'b0, stall}, 32'd1);
        end
        checkOutput("hold_cnt", {16'b0, mispred_cnt}, 32'd1);
        checkOutput("hold_no_bht_update", {31'b0, pred_taken}, 32'd1);
        releaseRedirect();

        // Unsigned select and a correctly predicted BLT.
        applyStimulus(1, 0, 3'b110, 32'h44, 32'h500, 0, 0, 0, 0);
        checkOutput("bltu_br_un", {31'b0, br_un}, 32'd1);
        step();
        applyStimulus(1, 0, 3'b100, 32'h44, 32'h500, 1, 0, 1, 0);
        checkOutput("blt_br_un", {31'b0, br_un}, 32'd0);
        step();
        checkOutput("blt_no_redirect", {31'b0, redir_valid}, 32'd0);

        // BNE at top of address space: fall-through wraps to zero.
        applyStimulus(1, 0, 3'b001, 32'hFFFF_FFFC, 32'h200, 1, 0, 0, 0);
        step();
        checkOutput("bne_no_redirect", {31'b0, redir_valid}, 32'd0);
        applyStimulus(1, 0, 3'b001, 32'hFFFF_FFFC, 32'h200, 1, 1, 0, 0);
        step();
        checkOutput("bne_wrap_valid", {31'b0, redir_valid}, 32'd1);
        checkOutput("bne_wrap_pc", redir_pc, 32'h0);
        checkOutput("bne_wrap_cnt", {16'b0, mispred_cnt}, 32'd2);
        releaseRedirect();

        // Jump always taken; illegal funct3 resolves not-taken; neither trains BHT.
        applyStimulus(1, 1, 3'b010, 32'h60, 32'h1234, 0, 0, 0, 0);
        step();
        checkOutput("jump_redir_pc", redir_pc, 32'h1234);
        checkOutput("jump_cnt", {16'b0, mispred_cnt}, 32'd3);
        releaseRedirect();
        applyStimulus(1, 0, 3'b011, 32'h64, 32'h9999, 1, 1, 1, 0);
        step();
        checkOutput("illegal_redir_pc", redir_pc, 32'h68);
        checkOutput("illegal_cnt", {16'b0, mispred_cnt}, 32'd4);
        releaseRedirect();
        pred_pc = 32'h60;
        #1 checkOutput("jump_no_bht_update", {31'b0, pred_taken}, 32'd0);

        // Counter walk on one entry: 01->10->11->11, then down to 00 and stay.
        pred_pc = 32'h1008;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 3'b000, 32'h1008, 32'h2000, 1, 1, 0, 0);
            if (k == 0) checkOutput("bht_old_on_write", {31'b0, pred_taken}, 32'd0);
            step();
        end
        checkOutput("bht_up_sat", {31'b0, pred_taken}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 3'b000, 32'h1008, 32'h2000, 0, 0, 0, 0);
            step();
            checkOutput("bht_down", {31'b0, pred_taken}, (k == 0) ? 32'd1 : 32'd0);
        end
        applyStimulus(1, 0, 3'b000, 32'h1008, 32'h2000, 1, 1, 0, 0);
        step();
        checkOutput("bht_low_sat", {31'b0, pred_taken}, 32'd0);
        checkOutput("bht_no_redirect", {31'b0, redir_valid}, 32'd0);
        applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 0);
        step();

        // Reset while a redirect is pending.
        applyStimulus(1, 0, 3'b000, 32'h40, 32'h700, 0, 1, 0, 0);
        step();
        checkOutput("pre_reset_valid", {31'b0, redir_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_redir_valid", {31'b0, redir_valid}, 32'd0);
        checkOutput("midrst_stall", {31'b0, stall}, 32'd0);
        checkOutput("midrst_cnt", {16'b0, mispred_cnt}, 32'd0);
        checkOutput("midrst_redir_pc", redir_pc, 32'h0);
        @(negedge clk);
        #1 pred_pc = 32'h40;
        #1 checkOutput("midrst_bht_40", {31'b0, pred_taken}, 32'd0);
        pred_pc = 32'h1008;
        #1 checkOutput("midrst_bht_1008", {31'b0, pred_taken}, 32'd0);
        applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        pred_pc = 32'h40;
        applyStimulus(1, 0, 3'b000, 32'h40, 32'h700, 1, 1, 0, 0);
        step();
        checkOutput("post_reset_bht_weak", {31'b0, pred_taken}, 32'd1);
        checkOutput("post_reset_no_redirect", {31'b0, redir_valid}, 32'd0);

        applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 0);
        repeat (3) step();
        checking = 0;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
